// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte
// sources, with an optional per-source lock for bounded multi-byte bursts.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_lock,
  output logic [N_REQ-1:0]          gnt,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [$clog2(N_REQ)-1:0]  cur_id,
  output logic                      busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  burst_cnt;

  logic [DATA_W-1:0] req_bytes [N_REQ];
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   next_ptr;
  logic              burst_ok;

  // Unpack the flat byte bus into one entry per source.
  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: first requesting source at or above ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % N_REQ);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Rotation point after the current owner, and whether it may keep the line.
  always_comb begin
    next_ptr = (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
    burst_ok = req_lock[cur_id] && req[cur_id] &&
               (burst_cnt < CNT_W'(MAX_BURST - 1));
  end

  // Arbitration FSM with registered grant, start pulse and byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      burst_cnt <= '0;
      gnt       <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      cur_id    <= '0;
      busy      <= 1'b0;
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_ready && win_found) begin
            gnt       <= N_REQ'(1) << win_id;
            tx_start  <= 1'b1;
            tx_data   <= req_bytes[win_id];
            cur_id    <= win_id;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!tx_ready) begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (tx_ready) begin
            if (burst_ok) begin
              gnt       <= N_REQ'(1) << cur_id;
              tx_start  <= 1'b1;
              tx_data   <= req_bytes[cur_id];
              burst_cnt <= burst_cnt + CNT_W'(1);
              state     <= WAIT_LOW;
            end else begin
              ptr   <= next_ptr;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  cur_id;
  logic        busy;

  logic [5:0]  tx_cnt;
  logic [3:0]  gnt_log [$];
  logic [7:0]  data_log [$];
  logic        prev_gnt;
  logic        consec_seen;
  logic        bad_onehot;
  logic        bad_start;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  uart_tx_arbiter #(
    .N_REQ     (4),
    .DATA_W    (8),
    .MAX_BURST (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_lock (req_lock),
    .gnt      (gnt),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .cur_id   (cur_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Transmitter: drops ready the cycle after start, raises it 20 cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ready <= 1'b1;
      tx_cnt   <= '0;
    end else if (tx_start) begin
      tx_ready <= 1'b0;
      tx_cnt   <= 6'd20;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 6'd1;
      if (tx_cnt == 6'd1) tx_ready <= 1'b1;
    end
  end

  // Grant recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (gnt !== 4'b0000) begin
      if (prev_gnt) consec_seen = 1'b1;
      if ($countones(gnt) != 1) bad_onehot = 1'b1;
      if (tx_start !== 1'b1) bad_start = 1'b1;
      gnt_log.push_back(gnt);
      data_log.push_back(tx_data);
    end else if (tx_start !== 1'b0) begin
      bad_start = 1'b1;
    end
    prev_gnt = (gnt !== 4'b0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    req_lock = '0;
    req_data = '0;
    repeat (2) tick();
    gnt_log.delete();
    data_log.delete();
    consec_seen = 1'b0;
    bad_onehot  = 1'b0;
    bad_start   = 1'b0;
    prev_gnt    = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_grants(input int n);
    int unsigned k;
    k = 0;
    while (gnt_log.size() < n && k < 400) begin
      tick();
      k++;
    end
    if (gnt_log.size() < n) begin
      chk_cnt++;
      $display("FAIL grant_timeout got %0d grants need %0d", gnt_log.size(), n);
    end
  endtask

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    if (busy) begin
      chk_cnt++;
      $display("FAIL idle_timeout busy still high");
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req      = 4'b1111;
    req_lock = '0;
    req_data = 32'hFFFF_FFFF;
    tick();
    chk_cnt++;
    if ({gnt, tx_start, tx_data, cur_id, busy} !== 16'h0)
      $display("FAIL reset_outputs got %h required 0", {gnt, tx_start, tx_data, cur_id, busy});
    else pass_cnt++;
    req = '0;
    rst = 1'b0;
    tick();
    chk_cnt++;
    if ({gnt, tx_start, tx_data, cur_id, busy} !== 16'h0)
      $display("FAIL post_reset_outputs got %h required 0", {gnt, tx_start, tx_data, cur_id, busy});
    else pass_cnt++;
    chk_cnt++;
    if (dut.ptr !== 2'd0) $display("FAIL reset_ptr got %0d required 0", dut.ptr);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    req      = 4'b0100;
    req_data = {8'h00, 8'h66, 8'h00, 8'h00};
    tick();
    chk_cnt++;
    if (gnt !== 4'b0100) $display("FAIL single_gnt got %b required 0100", gnt);
    else pass_cnt++;
    chk_cnt++;
    if (tx_start !== 1'b1 || tx_data !== 8'h66)
      $display("FAIL single_start got start=%b data=%h required 1/66", tx_start, tx_data);
    else pass_cnt++;
    chk_cnt++;
    if (cur_id !== 2'd2 || busy !== 1'b1)
      $display("FAIL single_id got id=%0d busy=%b required 2/1", cur_id, busy);
    else pass_cnt++;
    req = '0;
    tick();
    chk_cnt++;
    if (gnt !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h66)
      $display("FAIL single_pulse got gnt=%b start=%b data=%h required 0000/0/66", gnt, tx_start, tx_data);
    else pass_cnt++;
    wait_idle();
    chk_cnt++;
    if (dut.ptr !== 2'd3) $display("FAIL single_ptr got %0d required 3", dut.ptr);
    else pass_cnt++;
    chk_cnt++;
    if (gnt_log.size() != 1) $display("FAIL single_count got %0d required 1", gnt_log.size());
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [5];
    logic [7:0] ed [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    do_reset();
    req      = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    wait_grants(5);
    req = '0;
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      chk_cnt++;
      if (gnt_log[i] !== eg[i] || data_log[i] !== ed[i])
        $display("FAIL rr_grant%0d got %b/%h required %b/%h", i, gnt_log[i], data_log[i], eg[i], ed[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (gnt_log.size() != 5) $display("FAIL rr_count got %0d required 5", gnt_log.size());
    else pass_cnt++;
    chk_cnt++;
    if ({consec_seen, bad_onehot, bad_start} !== 3'b000)
      $display("FAIL rr_pulse_flags got %b required 000", {consec_seen, bad_onehot, bad_start});
    else pass_cnt++;
  endtask

  task automatic test_lock_burst();
    logic [3:0] eg [6];
    eg = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    do_reset();
    req      = 4'b0011;
    req_lock = 4'b0010;
    req_data = {8'h00, 8'h00, 8'hB1, 8'hB0};
    wait_grants(6);
    req      = '0;
    req_lock = '0;
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      chk_cnt++;
      if (gnt_log[i] !== eg[i])
        $display("FAIL burst_grant%0d got %b required %b", i, gnt_log[i], eg[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (data_log[4] !== 8'hB1 || data_log[5] !== 8'hB0)
      $display("FAIL burst_data got %h,%h required b1,b0", data_log[4], data_log[5]);
    else pass_cnt++;
    chk_cnt++;
    if (gnt_log.size() != 6 || {consec_seen, bad_onehot, bad_start} !== 3'b000)
      $display("FAIL burst_count got %0d flags %b required 6 000", gnt_log.size(), {consec_seen, bad_onehot, bad_start});
    else pass_cnt++;
  endtask

  task automatic test_lock_drop();
    do_reset();
    req      = 4'b0110;
    req_lock = 4'b0010;
    req_data = {8'h00, 8'h42, 8'h21, 8'h00};
    wait_grants(2);
    req_lock = '0;
    wait_grants(3);
    req = '0;
    wait_idle();
    chk_cnt++;
    if (gnt_log.size() != 3) $display("FAIL drop_count got %0d required 3", gnt_log.size());
    else pass_cnt++;
    chk_cnt++;
    if (gnt_log[0] !== 4'b0010 || gnt_log[1] !== 4'b0010)
      $display("FAIL drop_first got %b,%b required 0010,0010", gnt_log[0], gnt_log[1]);
    else pass_cnt++;
    chk_cnt++;
    if (gnt_log[2] !== 4'b0100 || data_log[2] !== 8'h42)
      $display("FAIL drop_next got %b/%h required 0100/42", gnt_log[2], data_log[2]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    req      = 4'b0100;
    req_data = {8'h00, 8'h77, 8'h00, 8'h00};
    wait_grants(1);
    req = '0;
    wait_idle();
    req      = 4'b0001;
    req_data = {8'h00, 8'h00, 8'h00, 8'h5C};
    wait_grants(2);
    req = '0;
    repeat (9) tick();
    chk_cnt++;
    if (busy !== 1'b1 || dut.ptr !== 2'd3)
      $display("FAIL midrst_pre got busy=%b ptr=%0d required 1/3", busy, dut.ptr);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || dut.ptr !== 2'd0)
      $display("FAIL midrst_async got busy=%b ptr=%0d required 0/0", busy, dut.ptr);
    else pass_cnt++;
    chk_cnt++;
    if ({gnt, tx_start, tx_data, cur_id} !== 15'h0)
      $display("FAIL midrst_outputs got %h required 0", {gnt, tx_start, tx_data, cur_id});
    else pass_cnt++;
    tick();
    tick();
    gnt_log.delete();
    data_log.delete();
    rst      = 1'b0;
    req      = 4'b1010;
    req_data = {8'h33, 8'h00, 8'h11, 8'h00};
    wait_grants(1);
    req = '0;
    chk_cnt++;
    if (gnt_log[0] !== 4'b0010 || data_log[0] !== 8'h11)
      $display("FAIL midrst_regrant got %b/%h required 0010/11", gnt_log[0], data_log[0]);
    else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_withdraw();
    do_reset();
    req      = 4'b0001;
    req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    tick();
    chk_cnt++;
    if (gnt !== 4'b0001) $display("FAIL wd_gnt got %b required 0001", gnt);
    else pass_cnt++;
    req      = 4'b1000;
    req_data = {8'hC3, 8'h00, 8'h00, 8'h5A};
    tick();
    req = '0;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL wd_busy got %b required 1", busy);
    else pass_cnt++;
    wait_idle();
    repeat (5) tick();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL wd_idle got busy=%b required 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (gnt_log.size() != 1 || gnt_log[0] !== 4'b0001)
      $display("FAIL wd_grants got count=%0d first=%b required 1/0001", gnt_log.size(), gnt_log[0]);
    else pass_cnt++;
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_lock = '0;
    req_data = '0;
    consec_seen = 1'b0;
    bad_onehot  = 1'b0;
    bad_start   = 1'b0;
    prev_gnt    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock_burst();
    test_lock_drop();
    test_reset_mid_frame();
    test_withdraw();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
